ama_riscv_mem_responder: RTL
============================

AMA_RISCV_MEM_RESPONDER -- requirements
Module: ama_riscv_mem_responder

Interface
REQ-001 Parameter DEPTH, default 4096, memory size in 32-bit words (16 KiB); SHALL be a power of two.
REQ-002 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  request offered by the core-side producer.
REQ-005 req_ready  output  1  responder can accept a request this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_mask  input  4  byte enables for writes; bit i covers byte lane i.
REQ-010 rsp_valid  output  1  response offered to the consumer.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_data  output  32  read data; 32'h0 for write responses.

Function
REQ-013 A request SHALL be accepted only in a cycle where req_valid and req_ready are both 1.
REQ-014 Every accepted request SHALL produce exactly one response, in acceptance order.
REQ-015 A response SHALL be consumed only in a cycle where rsp_valid and rsp_ready are both 1.
REQ-016 The FSM SHALL have the states IDLE, WAIT and RSP.
REQ-017 IDLE: req_ready=1 and rsp_valid=0; on acceptance the FSM SHALL go to RSP, or to WAIT when the delay feature is enabled.
REQ-018 WAIT: req_ready=0 and rsp_valid=0; the FSM SHALL go to RSP unconditionally after 1 cycle.
REQ-019 RSP: rsp_valid=1 and req_ready=rsp_ready.
REQ-020 RSP, rsp_ready=1 with a new acceptance: the FSM SHALL go back to RSP (or to WAIT with delay), giving back-to-back throughput of 1 transaction/cycle without the delay feature.
REQ-021 RSP, rsp_ready=1 with no acceptance: the FSM SHALL go to IDLE.
REQ-022 RSP, rsp_ready=0: the FSM SHALL stay in RSP, and rsp_data SHALL hold stable until consumed.
REQ-023 Word index SHALL be req_addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-024 A write SHALL update only the byte lanes with req_mask=1, in the acceptance cycle.
REQ-025 A write with req_mask=4'b0000 SHALL leave memory unchanged and still produce a response.
REQ-026 A read SHALL sample memory at acceptance and return that value; a read accepted in the cycle right after a write to the same word SHALL return the written data.
REQ-027 Request inputs SHALL be ignored when req_ready=0, whatever the value of req_valid.
REQ-028 rsp_data SHALL be registered; there SHALL be no combinational path from req_* to rsp_*.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE, with rsp_valid=0, rsp_data=32'h0 and req_ready=1 from the first cycle after reset.
REQ-030 Memory contents SHALL NOT be cleared by rst.
REQ-031 Reset asserted during WAIT or RSP SHALL drop the pending response without emitting it.

Configuration
REQ-032 Macro AMA_RISCV_MEM_RSP_DELAY_EN, when defined: every transaction SHALL pass through WAIT, giving a minimum latency of 2 cycles from acceptance to rsp_valid and a throughput of 1 transaction per 2 cycles.
REQ-033 Macro AMA_RISCV_MEM_RSP_DELAY_EN, when undefined: WAIT SHALL be unreachable and the minimum latency SHALL be 1 cycle.

Structure
REQ-034 The FSM state enum and the response data width SHALL live in the shared package ama_riscv_mem_pkg.
REQ-035 The byte-masked storage array SHALL be the sub-module ama_riscv_mem_array (synchronous write, registered read).
REQ-036 The FSM and handshake logic SHALL stay in the top module.

Verification
REQ-037 Write 0x4 data 0xDEADBEEF mask 4'hF, then read 0x4 -> rsp_data 0xDEADBEEF, 1 cycle after acceptance (2 with delay).
REQ-038 Write 0x8 mask 4'h2 data 0x0000AB00 over prior 0x11223344 -> read 0x8 returns 0x1122AB44.
REQ-039 rsp_ready held 0 for 5 cycles in RSP -> rsp_valid stays 1, rsp_data stable, req_ready=0, no second acceptance.
REQ-040 Continuous req_valid and rsp_ready over 8 reads, delay undefined -> 8 responses on 8 consecutive cycles, in order.
REQ-041 Write 0x0 = 0xCAFE0001, then read 0x10000 (DEPTH=4096) -> rsp_data 0xCAFE0001 (wrap-around).
REQ-042 rst asserted in RSP with rsp_ready=0 -> next cycle rsp_valid=0, rsp_data=0, req_ready=1; memory contents preserved.

Source files
------------

// File: rtl/ama_riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_mem_pkg
// Description : Shared types and widths for the memory responder slice.
// Revision    : 1.0 - initial release
// ============================================================================
package ama_riscv_mem_pkg;

  // Response data width and the matching number of byte lanes
  localparam int RSP_DATA_W = 32;
  localparam int MASK_W     = RSP_DATA_W / 8;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RSP  = 2'd2
  } mem_state_t;

endpackage : ama_riscv_mem_pkg
`default_nettype wire

// File: rtl/ama_riscv_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_mem_array
// Description : Byte-lane storage with synchronous masked write and a
//               registered read port. A write loads 0 into the read
//               register so write responses carry zero data. Reset clears
//               only the read register, never the storage.
// Revision    : 1.0 - initial release
// ============================================================================
module ama_riscv_mem_array
  import ama_riscv_mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         idx,
  input  logic [RSP_DATA_W-1:0] wdata,
  input  logic [MASK_W-1:0]     mask,
  output logic [RSP_DATA_W-1:0] rdata
);

  for (genvar i = 0; i < MASK_W; i++) begin : g_lane
    logic [7:0] r_lane_mem [DEPTH];
    logic [7:0] r_lane_q;

    // Storage write: only enabled lanes of an accepted write change
    always_ff @(posedge clk) begin
      if (en && we && mask[i]) begin
        r_lane_mem[idx] <= wdata[8*i +: 8];
      end
    end

    // Read register: captures the word on an accepted read, zero on a write
    always_ff @(posedge clk) begin
      if (rst) begin
        r_lane_q <= 8'h00;
      end else if (en) begin
        r_lane_q <= we ? 8'h00 : r_lane_mem[idx];
      end
    end

    assign rdata[8*i +: 8] = r_lane_q;
  end

endmodule : ama_riscv_mem_array
`default_nettype wire

// File: rtl/ama_riscv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_mem_responder
// Description : Single-outstanding valid/ready memory responder. Requests
//               are accepted in IDLE or in RSP while the current response
//               is consumed, giving one transaction per cycle back to back.
//               Optional macro AMA_RISCV_MEM_RSP_DELAY_EN routes every
//               transaction through a one-cycle WAIT state.
// Revision    : 1.0 - initial release
// ============================================================================
module ama_riscv_mem_responder
  import ama_riscv_mem_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RSP_DATA_W-1:0] rsp_data
);

  localparam int AW = $clog2(DEPTH);

`ifdef AMA_RISCV_MEM_RSP_DELAY_EN
  localparam mem_state_t ST_AFTER_ACCEPT = ST_WAIT;
`else
  localparam mem_state_t ST_AFTER_ACCEPT = ST_RSP;
`endif

  // Response becomes visible right after acceptance only without the delay
  localparam logic VALID_AFTER_ACCEPT = (ST_AFTER_ACCEPT == ST_RSP);

  mem_state_t r_state;
  logic       w_accept;
  logic       w_mem_en;
  logic       unused_addr_bits;

  // Ready in IDLE, or in RSP when the current response drains this cycle
  always_comb begin
    req_ready = 1'b0;
    case (r_state)
      ST_IDLE: req_ready = 1'b1;
      ST_RSP:  req_ready = rsp_ready;
      default: req_ready = 1'b0;
    endcase
  end

  assign w_accept = req_valid && req_ready;
  // A request seen while in reset must not touch the storage
  assign w_mem_en = w_accept && !rst;

  // Byte lanes [1:0] and bits above the word index do not select storage
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

  // Handshake FSM with a registered response-valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_AFTER_ACCEPT;
            rsp_valid <= VALID_AFTER_ACCEPT;
          end
        end
        ST_WAIT: begin
          r_state   <= ST_RSP;
          rsp_valid <= 1'b1;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            if (w_accept) begin
              r_state   <= ST_AFTER_ACCEPT;
              rsp_valid <= VALID_AFTER_ACCEPT;
            end else begin
              r_state   <= ST_IDLE;
              rsp_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  ama_riscv_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .en    (w_mem_en),
    .we    (req_we),
    .idx   (req_addr[AW+1:2]),
    .wdata (req_wdata),
    .mask  (req_mask),
    .rdata (rsp_data)
  );

endmodule : ama_riscv_mem_responder
`default_nettype wire
